// File: rtl/modexp_ctrl.sv
// Left-to-right square-and-multiply controller sequencing one shared Montgomery multiplier.
// Optional build macro MODEXP_SKIP_LEADING_ZEROS_EN: consume leading exponent zeros without squaring.
module modexp_ctrl #(
  parameter int N      = 1024,
  parameter int E_BITS = 1024
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              start_i,
  input  logic [N-1:0]      in_x_i,
  input  logic [E_BITS-1:0] in_e_i,
  input  logic [N-1:0]      in_m_i,
  input  logic [N-1:0]      in_r_i,
  input  logic [N-1:0]      in_r2_i,
  output logic              busy_o,
  output logic [N-1:0]      result_o,
  output logic              done_o,
  output logic              mul_start_o,
  output logic [N-1:0]      mul_a_o,
  output logic [N-1:0]      mul_b_o,
  output logic [N-1:0]      mul_m_o,
  input  logic [N-1:0]      mul_result_i,
  input  logic              mul_done_i
);
  // state  | meaning
  // IDLE   | waiting for start; operands captured on accept
  // ISSUE  | operands driven, one-cycle mul_start
  // WAIT   | operands held until mul_done, result written back
  // NEXT   | choose next op, advance exponent scan
  // DONE   | one-cycle done pulse, result valid
  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_NEXT, S_DONE} state_t;
  typedef enum logic [1:0] {OP_TOMONT, OP_SQ, OP_MUL, OP_FROM} op_t;

  localparam int CW = (E_BITS > 1) ? $clog2(E_BITS) : 1;

  state_t            state_q, state_d;
  op_t               op_q, op_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [E_BITS-1:0] e_q, e_d;
  logic [N-1:0]      x_q, x_d, m_q, m_d, r2_q, r2_d;
  logic [N-1:0]      xm_q, xm_d, acc_q, acc_d, result_q, result_d;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= S_IDLE;
      op_q     <= OP_TOMONT;
      cnt_q    <= '0;
      e_q      <= '0;
      x_q      <= '0;
      m_q      <= '0;
      r2_q     <= '0;
      xm_q     <= '0;
      acc_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      e_q      <= e_d;
      x_q      <= x_d;
      m_q      <= m_d;
      r2_q     <= r2_d;
      xm_q     <= xm_d;
      acc_q    <= acc_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    cnt_d       = cnt_q;
    e_d         = e_q;
    x_d         = x_q;
    m_d         = m_q;
    r2_d        = r2_q;
    xm_d        = xm_q;
    acc_d       = acc_q;
    result_d    = result_q;
    mul_start_o = 1'b0;
    mul_a_o     = '0;
    mul_b_o     = '0;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          x_d     = in_x_i;
          e_d     = in_e_i;
          m_d     = in_m_i;
          r2_d    = in_r2_i;
          acc_d   = in_r_i;
          cnt_d   = CW'(E_BITS - 1);
          op_d    = OP_TOMONT;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        mul_start_o = 1'b1;
        state_d     = S_WAIT;
      end
      S_WAIT: begin
        if (mul_done_i) begin
          if (op_q == OP_TOMONT) xm_d = mul_result_i;
          else                   acc_d = mul_result_i;
          state_d = S_NEXT;
        end
      end
      S_NEXT: begin
        state_d = S_ISSUE;
        case (op_q)
          OP_TOMONT: begin
`ifdef MODEXP_SKIP_LEADING_ZEROS_EN
            // op stays TOMONT while scanning leading zeros; acc remains R-form 1
            if (e_q[E_BITS-1]) begin
              op_d = OP_SQ;
            end else if (cnt_q != '0) begin
              cnt_d   = cnt_q - CW'(1);
              e_d     = e_q << 1;
              state_d = S_NEXT;
            end else begin
              op_d = OP_FROM;
            end
`else
            op_d = OP_SQ;
`endif
          end
          OP_SQ, OP_MUL: begin
            if (op_q == OP_SQ && e_q[E_BITS-1]) begin
              op_d = OP_MUL;
            end else if (cnt_q != '0) begin
              cnt_d = cnt_q - CW'(1);
              e_d   = e_q << 1;
              op_d  = OP_SQ;
            end else begin
              op_d = OP_FROM;
            end
          end
          OP_FROM: begin
            result_d = acc_q;
            state_d  = S_DONE;
          end
          default: state_d = S_IDLE;
        endcase
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (state_q == S_ISSUE || state_q == S_WAIT) begin
      case (op_q)
        OP_TOMONT: begin mul_a_o = x_q;   mul_b_o = r2_q;   end
        OP_SQ:     begin mul_a_o = acc_q; mul_b_o = acc_q;  end
        OP_MUL:    begin mul_a_o = acc_q; mul_b_o = xm_q;   end
        default:   begin mul_a_o = acc_q; mul_b_o = N'(1);  end
      endcase
    end
  end

  assign mul_m_o  = m_q;
  assign busy_o   = (state_q == S_ISSUE) || (state_q == S_WAIT) || (state_q == S_NEXT);
  assign done_o   = (state_q == S_DONE);
  assign result_o = result_q;

endmodule

// File: tb/tb_modexp_ctrl.sv
// Bench for modexp_ctrl: behavioural Montgomery multiplier (L=3), golden modpow scoreboard.
module tb_modexp_ctrl;
  localparam int N  = 24;
  localparam int EB = 8;
  localparam int L  = 3;

  logic          clk = 1'b0;
  logic          reset_i = 1'b1;
  logic          start_i = 1'b0;
  logic [N-1:0]  in_x_i = '0, in_m_i = '0, in_r_i = '0, in_r2_i = '0;
  logic [EB-1:0] in_e_i = '0;
  logic          busy_o, done_o, mul_start_o, mul_done_i;
  logic [N-1:0]  result_o, mul_a_o, mul_b_o, mul_m_o, mul_result_i;

  modexp_ctrl #(.N(N), .E_BITS(EB)) dut (
    .clk_i(clk), .reset_i(reset_i), .start_i(start_i),
    .in_x_i(in_x_i), .in_e_i(in_e_i), .in_m_i(in_m_i), .in_r_i(in_r_i), .in_r2_i(in_r2_i),
    .busy_o(busy_o), .result_o(result_o), .done_o(done_o),
    .mul_start_o(mul_start_o), .mul_a_o(mul_a_o), .mul_b_o(mul_b_o), .mul_m_o(mul_m_o),
    .mul_result_i(mul_result_i), .mul_done_i(mul_done_i)
  );

  initial forever #5 clk = ~clk;

  typedef struct { longint res; int calls; } exp_t;
  exp_t sb[$];
  int total = 0, bad = 0;
  int mul_calls = 0, done_cnt = 0, stab_err = 0;
  bit spur_tog = 1'b0;

  function automatic logic [N-1:0] montmul(logic [N-1:0] a, logic [N-1:0] b, logic [N-1:0] m);
    longint t = 0;
    for (int i = 0; i < N; i++) begin
      if (a[i]) t = t + longint'(b);
      if (t[0]) t = t + longint'(m);
      t = t >> 1;
    end
    if (t >= longint'(m)) t = t - longint'(m);
    return N'(t);
  endfunction

  function automatic longint modpow(longint x, logic [EB-1:0] e, longint m);
    longint r = 1 % m;
    longint b = x % m;
    for (int i = EB - 1; i >= 0; i--) begin
      r = (r * r) % m;
      if (e[i]) r = (r * b) % m;
    end
    return r;
  endfunction

  function automatic int exp_calls(logic [EB-1:0] e);
`ifdef MODEXP_SKIP_LEADING_ZEROS_EN
    int lz = 0;
    bit one = 1'b0;
    for (int i = EB - 1; i >= 0; i--) begin
      if (e[i]) one = 1'b1;
      else if (!one) lz++;
    end
    return 2 + (EB - lz) + $countones(e);
`else
    return 2 + EB + $countones(e);
`endif
  endfunction

  // Multiplier model: latches operands on mul_start, answers L cycles later.
  initial begin
    int pend;
    bit last_tog;
    logic [N-1:0] la, lb, lm;
    pend = 0; last_tog = 1'b0; la = '0; lb = '0; lm = '0;
    mul_done_i = 1'b0; mul_result_i = '0;
    forever begin
      @(posedge clk); #1;
      mul_done_i = 1'b0;
      if (reset_i) pend = 0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          if (mul_a_o !== la || mul_b_o !== lb || mul_m_o !== lm) stab_err++;
          mul_result_i = montmul(la, lb, lm);
          mul_done_i   = 1'b1;
        end
      end
      if (spur_tog != last_tog) begin
        last_tog     = spur_tog;
        mul_result_i = 24'h5a5a5a;
        mul_done_i   = 1'b1;
      end
      if (mul_start_o === 1'b1 && !reset_i) begin
        la = mul_a_o; lb = mul_b_o; lm = mul_m_o;
        pend = L;
        mul_calls++;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (done_o === 1'b1) done_cnt++;
  end

  task automatic run_job(input logic [N-1:0] x, input logic [EB-1:0] e, input logic [N-1:0] m,
                         input bit disturb, output longint res, output int calls,
                         output bit seen, output bit busy_at_done, output int dones,
                         output logic [N-1:0] held);
    longint r, r2;
    int c0, d0;
    r  = (longint'(1) << N) % longint'(m);
    r2 = (r * r) % longint'(m);
    in_x_i = x; in_e_i = e; in_m_i = m; in_r_i = N'(r); in_r2_i = N'(r2);
    sb.push_back('{modpow(longint'(x), e, longint'(m)), exp_calls(e)});
    c0 = mul_calls; d0 = done_cnt;
    res = 0; seen = 1'b0; busy_at_done = 1'b1;
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    for (int k = 0; k < 600 && !seen; k++) begin
      @(negedge clk);
      if (disturb && k == 2) begin
        start_i = 1'b1; in_x_i = ~x; in_e_i = ~e;
      end
      if (disturb && k == 5) start_i = 1'b0;
      if (done_o === 1'b1) begin
        seen = 1'b1; res = longint'(result_o); busy_at_done = busy_o;
      end
    end
    calls = mul_calls - c0;
    @(negedge clk);
    @(negedge clk);
    dones = done_cnt - d0;
    held  = result_o;
  endtask

  task automatic check_job(input string name, input longint res, input int calls, input bit seen,
                           input bit busy_at_done, input int dones, input logic [N-1:0] held);
    exp_t ex;
    ex = sb.pop_front();
    total++;
    if (!seen) begin
      bad++; $display("FAIL %s timeout: no done within budget, required done=1", name);
    end
    total++;
    if (res !== ex.res) begin
      bad++; $display("FAIL %s result: got %0d required %0d", name, res, ex.res);
    end
    total++;
    if (calls !== ex.calls) begin
      bad++; $display("FAIL %s mul_start count: got %0d required %0d", name, calls, ex.calls);
    end
    total++;
    if (dones !== 1) begin
      bad++; $display("FAIL %s done pulses: got %0d required 1", name, dones);
    end
    total++;
    if (busy_at_done !== 1'b0 || held !== N'(ex.res)) begin
      bad++; $display("FAIL %s busy/held: busy=%0b held=%0d required busy=0 held=%0d",
                      name, busy_at_done, held, ex.res);
    end
  endtask

  longint g_res; int g_calls, g_dones; bit g_seen, g_busy; logic [N-1:0] g_held;

  task automatic test_reset();
    reset_i = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if ({busy_o, done_o, mul_start_o} !== 3'b000) begin
      bad++; $display("FAIL reset ctrl: busy/done/mul_start=%b required 000", {busy_o, done_o, mul_start_o});
    end
    total++;
    if (result_o !== '0 || mul_a_o !== '0 || mul_b_o !== '0 || mul_m_o !== '0) begin
      bad++; $display("FAIL reset data: result=%0h a=%0h b=%0h m=%0h required all 0",
                      result_o, mul_a_o, mul_b_o, mul_m_o);
    end
    reset_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_small();
    run_job(24'd3, 8'd5, 24'd7, 1'b0, g_res, g_calls, g_seen, g_busy, g_dones, g_held);
    check_job("small_3_5_7", g_res, g_calls, g_seen, g_busy, g_dones, g_held);
    total++;
    if (g_res !== 64'd5) begin
      bad++; $display("FAIL small literal: got %0d required 5", g_res);
    end
  endtask

  task automatic test_edges();
    run_job(24'd9, 8'd0, 24'd13, 1'b0, g_res, g_calls, g_seen, g_busy, g_dones, g_held);
    check_job("e_zero", g_res, g_calls, g_seen, g_busy, g_dones, g_held);
    run_job(24'd12, 8'd1, 24'd13, 1'b0, g_res, g_calls, g_seen, g_busy, g_dones, g_held);
    check_job("e_one", g_res, g_calls, g_seen, g_busy, g_dones, g_held);
    run_job(24'd5, 8'hff, 24'hfffffd, 1'b0, g_res, g_calls, g_seen, g_busy, g_dones, g_held);
    check_job("e_all_ones", g_res, g_calls, g_seen, g_busy, g_dones, g_held);
  endtask

  task automatic test_random();
    logic [N-1:0] m, x;
    logic [EB-1:0] e;
    for (int i = 0; i < 5; i++) begin
      m = N'($urandom_range(3, (1 << N) - 1)) | N'(1);
      x = N'($urandom % m);
      e = EB'($urandom);
      run_job(x, e, m, 1'b0, g_res, g_calls, g_seen, g_busy, g_dones, g_held);
      check_job("random", g_res, g_calls, g_seen, g_busy, g_dones, g_held);
    end
  endtask

  task automatic test_start_ignored();
    run_job(24'd123457, 8'hb3, 24'd999983, 1'b1, g_res, g_calls, g_seen, g_busy, g_dones, g_held);
    check_job("start_while_busy", g_res, g_calls, g_seen, g_busy, g_dones, g_held);
  endtask

  task automatic test_reset_abort();
    bit saw_start, saw_busy;
    int d0;
    in_x_i = 24'd5; in_e_i = 8'hff; in_m_i = 24'd101; in_r_i = 24'd1; in_r2_i = 24'd1;
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    saw_start = 1'b0;
    for (int k = 0; k < 20 && !saw_start; k++) begin
      if (mul_start_o === 1'b1) saw_start = 1'b1;
      else @(negedge clk);
    end
    total++;
    if (!saw_start) begin
      bad++; $display("FAIL abort setup: mul_start not seen, required 1");
    end
    repeat (2) @(negedge clk);
    reset_i = 1'b1;
    d0 = done_cnt;
    @(negedge clk);
    total++;
    if ({busy_o, done_o, mul_start_o} !== 3'b000 || result_o !== '0 ||
        mul_a_o !== '0 || mul_b_o !== '0 || mul_m_o !== '0) begin
      bad++; $display("FAIL abort reset values: busy=%0b done=%0b ms=%0b result=%0h a=%0h b=%0h m=%0h required all 0",
                      busy_o, done_o, mul_start_o, result_o, mul_a_o, mul_b_o, mul_m_o);
    end
    reset_i = 1'b0;
    spur_tog = ~spur_tog;
    saw_busy = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (busy_o !== 1'b0 || mul_start_o !== 1'b0) saw_busy = 1'b1;
    end
    total++;
    if (saw_busy || done_cnt != d0) begin
      bad++; $display("FAIL abort idle: busy_seen=%0b dones=%0d required 0 and 0", saw_busy, done_cnt - d0);
    end
    run_job(24'd2, 8'd10, 24'd1000003, 1'b0, g_res, g_calls, g_seen, g_busy, g_dones, g_held);
    check_job("after_abort", g_res, g_calls, g_seen, g_busy, g_dones, g_held);
    total++;
    if (g_res !== 64'd1024) begin
      bad++; $display("FAIL after_abort literal: got %0d required 1024", g_res);
    end
  endtask

  task automatic test_operand_stability();
    total++;
    if (stab_err !== 0) begin
      bad++; $display("FAIL operand stability: %0d calls changed operands before mul_done, required 0", stab_err);
    end
  endtask

  initial begin
    test_reset();
    test_small();
    test_edges();
    test_random();
    test_start_ignored();
    test_reset_abort();
    test_operand_stability();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
